// File: rtl/flick_debouncer.sv
// Push-button conditioner: synchronises and debounces a raw button level, then
// emits fixed-width flick pulses on each accepted press, with optional auto-repeat.
module flick_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_WIDTH     = 1,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             flick,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_sync;
    logic [DB_W-1:0]        db_cnt, db_nx;
    logic [REP_W-1:0]       rep_cnt, rep_nx;
    logic [PW_W-1:0]        pw_cnt;
    logic                   level_nx;
    logic                   start_pulse;
    logic                   press_inc;

    assign btn_sync  = sync[SYNC_STAGES-1];
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            btn_level <= 1'b0;
            press_cnt <= '0;
        end else begin
            state     <= state_nx;
            db_cnt    <= db_nx;
            rep_cnt   <= rep_nx;
            btn_level <= level_nx;
            if (press_inc) begin
                press_cnt <= press_cnt + 1'b1;
            end
        end
    end

    // A release seen in HELD wins over a repeat that would fire on the same edge.
    always_comb begin
        state_nx    = state;
        db_nx       = db_cnt;
        rep_nx      = rep_cnt;
        level_nx    = btn_level;
        start_pulse = 1'b0;
        press_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nx = PRESS_WAIT;
                    db_nx    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nx = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nx    = HELD;
                    level_nx    = 1'b1;
                    press_inc   = 1'b1;
                    start_pulse = 1'b1;
                    rep_nx      = '0;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_nx = RELEASE_WAIT;
                    db_nx    = '0;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_cnt == REP_LAST) begin
                        start_pulse = 1'b1;
                        rep_nx      = '0;
                    end else begin
                        rep_nx = rep_cnt + 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nx = HELD;
                    rep_nx   = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx = IDLE;
                    level_nx = 1'b0;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A new start reloads the width counter, so overlapping starts extend rather than stick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flick  <= 1'b0;
            pw_cnt <= '0;
        end else if (start_pulse) begin
            flick  <= 1'b1;
            pw_cnt <= PW_LAST;
        end else if (flick) begin
            if (pw_cnt == '0) begin
                flick <= 1'b0;
            end else begin
                pw_cnt <= pw_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flick_debouncer.sv
// Directed bench for flick_debouncer: a plain instance and an auto-repeat instance
// with a 2-bit press counter share one button input.
module tb_flick_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       flick_a, level_a, flick_b, level_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;
    int pa, pb;
    logic [31:0] seq_a, seq_b;

    always #5 clk = ~clk;

    flick_debouncer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(1), .REPEAT_CYCLES(0), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .flick(flick_a),
        .btn_level(level_a), .press_cnt(cnt_a), .dbg_state(st_a)
    );

    flick_debouncer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(2), .REPEAT_CYCLES(8), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in), .flick(flick_b),
        .btn_level(level_b), .press_cnt(cnt_b), .dbg_state(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps n cycles, counting cycles on which each flick output is high.
    task automatic run_count(input int n, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (flick_a) ca++;
            if (flick_b) cb++;
        end
    endtask

    initial begin
        rst    = 1'b0;
        btn_in = 1'b0;
        tick(3);
        check("reset_flick_a", flick_a, 0);
        check("reset_level_a", level_a, 0);
        check("reset_cnt_a", cnt_a, 0);
        check("reset_state_a", st_a, 0);
        check("reset_flick_b", flick_b, 0);
        rst = 1'b1;
        tick(2);

        // Clean press: flick at E0+6 on both, repeats on dut_b every 8 cycles, 2 wide.
        btn_in = 1'b1;
        seq_a  = '0;
        seq_b  = '0;
        for (int t = 1; t <= 26; t++) begin
            tick(1);
            seq_a[t] = flick_a;
            seq_b[t] = flick_b;
            if (t == 6) check("press_level_before", level_a, 0);
            if (t == 7) begin
                check("press_level_a", level_a, 1);
                check("press_cnt_a", cnt_a, 1);
                check("press_cnt_b", cnt_b, 1);
                check("press_state_a", st_a, 2);
            end
        end
        check("press_flick_a_seq", seq_a, 32'h0000_0080);
        check("repeat_flick_b_seq", seq_b, 32'h0181_8180);

        // Clean release: level drops 6 edges after the first low sample, no pulse.
        btn_in = 1'b0;
        seq_a  = '0;
        seq_b  = '0;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            seq_a[t] = flick_a;
            seq_b[t] = flick_b;
            if (t == 6) check("release_level_before", level_a, 1);
            if (t == 7) check("release_level_a", level_a, 0);
        end
        check("release_no_flick_a", seq_a, 0);
        check("release_no_flick_b", seq_b, 0);

        // Glitch: 3 cycles high is rejected.
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        run_count(15, pa, pb);
        check("glitch_flick_a", pa, 0);
        check("glitch_flick_b", pb, 0);
        check("glitch_level_a", level_a, 0);
        check("glitch_cnt_a", cnt_a, 1);
        check("glitch_state_a", st_a, 0);

        // Bouncy press then bouncy release: exactly one pulse.
        pa = 0;
        for (int i = 0; i < 14; i++) begin
            btn_in = (i >= 4) ? 1'b1 : ((i % 2) == 0);
            tick(1);
            if (flick_a) pa++;
        end
        check("bounce_press_pulses", pa, 1);
        check("bounce_press_level", level_a, 1);
        check("bounce_press_cnt", cnt_a, 2);
        pa = 0;
        for (int i = 0; i < 14; i++) begin
            btn_in = (i >= 4) ? 1'b0 : ((i % 2) == 1);
            tick(1);
            if (flick_a) pa++;
        end
        check("bounce_release_pulses", pa, 0);
        check("bounce_release_level", level_a, 0);
        check("bounce_release_cnt", cnt_a, 2);

        // Reset while in PRESS_WAIT with cnt=2, button held through reset release.
        btn_in = 1'b1;
        tick(5);
        check("mid_state_a", st_a, 1);
        rst = 1'b0;
        #1;
        check("mid_reset_state_a", st_a, 0);
        check("mid_reset_cnt_a", cnt_a, 0);
        check("mid_reset_cnt_b", cnt_b, 0);
        tick(2);
        check("mid_reset_flick_a", flick_a, 0);
        check("mid_reset_level_a", level_a, 0);
        rst = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick(1);
            if (t == 6) begin
                check("post_reset_flick_early", flick_a, 0);
                check("post_reset_level_early", level_a, 0);
            end
            if (t == 7) begin
                check("post_reset_flick_a", flick_a, 1);
                check("post_reset_flick_b", flick_b, 1);
                check("post_reset_level_a", level_a, 1);
                check("post_reset_cnt_a", cnt_a, 1);
                check("post_reset_cnt_b", cnt_b, 1);
            end
        end
        btn_in = 1'b0;
        tick(10);
        check("post_reset_release_level", level_a, 0);

        // Three more presses: 2-bit counter goes 1 -> 2 -> 3 -> 0.
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b1;
            tick(8);
            btn_in = 1'b0;
            tick(8);
            if (i == 1) check("wrap_cnt_b_3", cnt_b, 3);
        end
        check("wrap_cnt_b_0", cnt_b, 0);
        check("wrap_cnt_a_4", cnt_a, 4);
        check("wrap_level_b", level_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
